// File: rtl/disp_arbiter.sv
// Shares one 4-digit seven-segment display between clock time, digit editing
// and one-shot messages (priority message > edit > time); owns blink and hold timing.
module disp_arbiter #(
  parameter int TICK_DIV    = 500000,
  parameter int BLINK_TICKS = 50,
  parameter int MSG_TICKS   = 400
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] time_hexs,
  input  logic [3:0]  time_pts,
  input  logic        edit_req,
  input  logic [15:0] edit_hexs,
  input  logic [3:0]  edit_pts,
  input  logic [3:0]  edit_blink,
  input  logic        msg_start,
  input  logic [15:0] msg_hexs,
  input  logic [3:0]  msg_pts,
  input  logic [3:0]  msg_les,
  output logic [15:0] HEXS,
  output logic [3:0]  LES,
  output logic [3:0]  points,
  output logic [1:0]  src,
  output logic        msg_busy,
  output logic        blink_phase
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int MW = $clog2(MSG_TICKS + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [MW-1:0] MSG_LOAD   = MW'(MSG_TICKS);
  localparam logic [MW-1:0] MSG_ONE    = MW'(1);

  // The encoding doubles as the src output, so the FSM state is always observable.
  typedef enum logic [1:0] {
    ST_TIME = 2'd0,
    ST_EDIT = 2'd1,
    ST_MSG  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [MW-1:0] msg_cnt_q, msg_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [15:0]   msg_hexs_q, msg_hexs_d;
  logic [3:0]    msg_pts_q, msg_pts_d;
  logic [3:0]    msg_les_q, msg_les_d;
  logic [15:0]   hexs_q, hexs_d;
  logic [3:0]    les_q, les_d;
  logic [3:0]    points_q, points_d;
  logic          msg_busy_q, msg_busy_d;
  logic          tick;
  logic          edit_entry;

  always_comb begin
    tick          = (presc_q == PRESC_LAST);
    state_d       = state_q;
    presc_d       = presc_q;
    msg_cnt_d     = msg_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    msg_hexs_d    = msg_hexs_q;
    msg_pts_d     = msg_pts_q;
    msg_les_d     = msg_les_q;
    hexs_d        = time_hexs;
    les_d         = 4'b1111;
    points_d      = time_pts;
    msg_busy_d    = 1'b0;

    case (state_q)
      ST_TIME: if (edit_req) state_d = ST_EDIT;
      ST_EDIT: if (!edit_req) state_d = ST_TIME;
      ST_MSG: begin
        if (tick && (msg_cnt_q == MSG_ONE)) begin
          state_d = edit_req ? ST_EDIT : ST_TIME;
        end
      end
      default: state_d = ST_TIME;
    endcase
    // A message request overrides every other transition, including expiry.
    if (msg_start) state_d = ST_MSG;

    edit_entry = (state_d == ST_EDIT) && (state_q != ST_EDIT);

    presc_d = tick ? '0 : presc_q + PW'(1);
    if (msg_start || edit_entry) presc_d = '0;

    if (msg_start) begin
      msg_cnt_d  = MSG_LOAD;
      msg_hexs_d = msg_hexs;
      msg_pts_d  = msg_pts;
      msg_les_d  = msg_les;
    end else if ((state_q == ST_MSG) && tick && (msg_cnt_q != '0)) begin
      msg_cnt_d = msg_cnt_q - MW'(1);
    end

    // Restart blinking lit so the edited digit shows the moment editing begins.
    if (edit_entry) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if ((state_q == ST_EDIT) && (state_d == ST_EDIT) && tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    case (state_d)
      ST_EDIT: begin
        hexs_d   = edit_hexs;
        points_d = edit_pts;
        les_d    = blink_phase_d ? 4'b1111 : ~edit_blink;
      end
      ST_MSG: begin
        hexs_d     = msg_hexs_d;
        points_d   = msg_pts_d;
        les_d      = msg_les_d;
        msg_busy_d = 1'b1;
      end
      default: begin
        hexs_d   = time_hexs;
        points_d = time_pts;
        les_d    = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_TIME;
      presc_q       <= '0;
      msg_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      msg_hexs_q    <= '0;
      msg_pts_q     <= '0;
      msg_les_q     <= '0;
      hexs_q        <= '0;
      les_q         <= '0;
      points_q      <= '0;
      msg_busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      msg_cnt_q     <= msg_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      msg_hexs_q    <= msg_hexs_d;
      msg_pts_q     <= msg_pts_d;
      msg_les_q     <= msg_les_d;
      hexs_q        <= hexs_d;
      les_q         <= les_d;
      points_q      <= points_d;
      msg_busy_q    <= msg_busy_d;
    end
  end

  assign HEXS        = hexs_q;
  assign LES         = les_q;
  assign points      = points_q;
  assign src         = state_q;
  assign msg_busy    = msg_busy_q;
  assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter with short timing (TICK_DIV=4, BLINK_TICKS=2,
// MSG_TICKS=3); inputs change and outputs are checked on the falling edge.
module tb_disp_arbiter;

  logic        clk = 1'b0;
  logic        RST;
  logic [15:0] time_hexs;
  logic [3:0]  time_pts;
  logic        edit_req;
  logic [15:0] edit_hexs;
  logic [3:0]  edit_pts;
  logic [3:0]  edit_blink;
  logic        msg_start;
  logic [15:0] msg_hexs;
  logic [3:0]  msg_pts;
  logic [3:0]  msg_les;
  logic [15:0] HEXS;
  logic [3:0]  LES;
  logic [3:0]  points;
  logic [1:0]  src;
  logic        msg_busy;
  logic        blink_phase;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_les;

  disp_arbiter #(.TICK_DIV(4), .BLINK_TICKS(2), .MSG_TICKS(3)) dut (
    .clk(clk), .RST(RST),
    .time_hexs(time_hexs), .time_pts(time_pts),
    .edit_req(edit_req), .edit_hexs(edit_hexs), .edit_pts(edit_pts), .edit_blink(edit_blink),
    .msg_start(msg_start), .msg_hexs(msg_hexs), .msg_pts(msg_pts), .msg_les(msg_les),
    .HEXS(HEXS), .LES(LES), .points(points), .src(src),
    .msg_busy(msg_busy), .blink_phase(blink_phase)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_msg(input logic [15:0] hx, input logic [3:0] les);
    msg_hexs  = hx;
    msg_les   = les;
    msg_pts   = 4'b0000;
    msg_start = 1'b1;
    cycles(1);
    msg_start = 1'b0;
    msg_hexs  = 16'h0000;
    msg_les   = 4'b0000;
  endtask

  initial begin
    RST = 1'b0;
    time_hexs = 16'h1234; time_pts = 4'b0100;
    edit_req = 1'b0; edit_hexs = 16'h0930; edit_pts = 4'b0000; edit_blink = 4'b0011;
    msg_start = 1'b0; msg_hexs = 16'h0000; msg_pts = 4'b0000; msg_les = 4'b0000;

    // reset values while RST is held low
    cycles(2);
    chk("rst_hexs", HEXS, 16'h0000);
    chk("rst_les", {12'h0, LES}, 16'h0000);
    chk("rst_blink", {15'h0, blink_phase}, 16'h0001);
    chk("rst_src", {14'h0, src}, 16'h0000);
    chk("rst_busy", {15'h0, msg_busy}, 16'h0000);

    RST = 1'b1;
    cycles(1);
    chk("time_hexs", HEXS, 16'h1234);
    chk("time_les", {12'h0, LES}, 16'h000F);
    chk("time_pts", {12'h0, points}, 16'h0004);
    chk("time_src", {14'h0, src}, 16'h0000);

    // edit mode: lit 8 cycles, blinking digits off 8 cycles, lit again
    cycles(3);
    edit_req = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(4'b1111);
    for (int i = 0; i < 8; i++) exp_q.push_back(4'b1100);
    for (int i = 0; i < 8; i++) exp_q.push_back(4'b1111);
    cycles(1);
    chk("edit_src", {14'h0, src}, 16'h0001);
    chk("edit_hexs", HEXS, 16'h0930);
    for (int i = 0; i < 24; i++) begin
      if (i != 0) cycles(1);
      exp_les = exp_q.pop_front();
      chk($sformatf("edit_les_%0d", i), {12'h0, LES}, {12'h0, exp_les});
      chk($sformatf("edit_phase_%0d", i), {15'h0, blink_phase}, {15'h0, exp_les[0]});
    end
    edit_req = 1'b0;
    cycles(1);
    chk("edit_exit_src", {14'h0, src}, 16'h0000);
    chk("edit_exit_hexs", HEXS, 16'h1234);
    time_hexs = 16'h5678;
    cycles(1);
    chk("time_latency", HEXS, 16'h5678);
    time_hexs = 16'h1234;

    // single message: exactly 12 cycles
    cycles(2);
    send_msg(16'hAEEE, 4'b1000);
    chk("msg_hexs", HEXS, 16'hAEEE);
    chk("msg_les", {12'h0, LES}, 16'h0008);
    for (int i = 1; i <= 12; i++) begin
      if (i != 1) cycles(1);
      chk($sformatf("msg_src_%0d", i), {14'h0, src}, 16'h0002);
      chk($sformatf("msg_busy_%0d", i), {15'h0, msg_busy}, 16'h0001);
    end
    chk("msg_hold_hexs", HEXS, 16'hAEEE);
    cycles(1);
    chk("msg_end_busy", {15'h0, msg_busy}, 16'h0000);
    chk("msg_end_src", {14'h0, src}, 16'h0000);
    chk("msg_end_hexs", HEXS, 16'h1234);

    // retrigger six cycles in: 18 message cycles total
    cycles(2);
    send_msg(16'hAEEE, 4'b1000);
    cycles(5);
    chk("retrig_before", HEXS, 16'hAEEE);
    send_msg(16'hBBBB, 4'b1111);
    chk("retrig_hexs", HEXS, 16'hBBBB);
    for (int i = 7; i <= 18; i++) begin
      if (i != 7) cycles(1);
      chk($sformatf("retrig_busy_%0d", i), {15'h0, msg_busy}, 16'h0001);
    end
    cycles(1);
    chk("retrig_end_busy", {15'h0, msg_busy}, 16'h0000);
    chk("retrig_end_src", {14'h0, src}, 16'h0000);

    // message together with edit_req rising; edit_req wobble ignored; exit to edit
    cycles(2);
    edit_req = 1'b1;
    send_msg(16'hCAFE, 4'b0110);
    chk("msg_edit_first_src", {14'h0, src}, 16'h0002);
    cycles(3);
    edit_req = 1'b0;
    cycles(2);
    chk("msg_edit_wobble_src", {14'h0, src}, 16'h0002);
    edit_req = 1'b1;
    cycles(6);
    chk("msg_edit_last_src", {14'h0, src}, 16'h0002);
    for (int i = 13; i <= 20; i++) begin
      cycles(1);
      chk($sformatf("post_msg_src_%0d", i), {14'h0, src}, 16'h0001);
      chk($sformatf("post_msg_les_%0d", i), {12'h0, LES}, 16'h000F);
      chk($sformatf("post_msg_phase_%0d", i), {15'h0, blink_phase}, 16'h0001);
    end
    cycles(1);
    chk("post_msg_les_off", {12'h0, LES}, 16'h000C);
    chk("post_msg_phase_off", {15'h0, blink_phase}, 16'h0000);

    // asynchronous reset in the middle of a message
    send_msg(16'hDDDD, 4'b1111);
    cycles(2);
    RST = 1'b0;
    #1;
    chk("async_rst_hexs", HEXS, 16'h0000);
    chk("async_rst_les", {12'h0, LES}, 16'h0000);
    chk("async_rst_src", {14'h0, src}, 16'h0000);
    chk("async_rst_busy", {15'h0, msg_busy}, 16'h0000);
    chk("async_rst_phase", {15'h0, blink_phase}, 16'h0001);
    edit_req = 1'b0;
    cycles(2);
    RST = 1'b1;
    cycles(1);
    chk("after_rst_busy", {15'h0, msg_busy}, 16'h0000);
    chk("after_rst_src", {14'h0, src}, 16'h0000);
    chk("after_rst_hexs", HEXS, 16'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Schedules the shared 4-digit seven-segment display between three requesters:
  - running clock time (background),
  - digit-edit mode (set time/alarm, with per-digit blinking),
  - one-shot transient messages.
- Drives the HEXS/LES/points inputs of the DispNum display driver. Fixed priority: message > edit > time.
- Owns the blink timing and the message hold timer.

Parameters:
- TICK_DIV, 500000: clk cycles per internal tick (5 ms at 100 MHz).
- BLINK_TICKS, 50: ticks per blink half-period.
- MSG_TICKS, 400: ticks a message is held on the display.

Ports:
- clk  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- time_hexs  in  16  clock-time digits, 4 hex nibbles, [15:12] = leftmost.
- time_pts  in  4  clock-time decimal points.
- edit_req  in  1  level; 1 = edit mode wants the display.
- edit_hexs  in  16  edit-mode digits.
- edit_pts  in  4  edit-mode decimal points.
- edit_blink  in  4  1 = digit blinks in edit mode.
- msg_start  in  1  single-cycle pulse; starts or retriggers a message.
- msg_hexs  in  16  message digits, captured on msg_start.
- msg_pts  in  4  message points, captured on msg_start.
- msg_les  in  4  message digit enables (1 = lit), captured on msg_start.
- HEXS  out  16  to DispNum.
- LES  out  4  to DispNum, 1 = digit shown.
- points  out  4  to DispNum.
- src  out  2  current owner: 0 = time, 1 = edit, 2 = message.
- msg_busy  out  1  1 while a message owns the display.
- blink_phase  out  1  1 = blinking digits currently lit.

Behaviour:
- Reset (RST = 0, asynchronous):
  - HEXS = 0, LES = 4'b0000, points = 0, src = 0, msg_busy = 0, blink_phase = 1.
  - State = TIME; all counters = 0; captured message registers = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick = 1 for one cycle when the count is TICK_DIV-1, then wraps to 0.
  - Cleared to 0 on msg_start and on entry to EDIT.
- States:
  - TIME: edit_req = 1 → EDIT.
  - EDIT: edit_req = 0 → TIME.
  - MSG: exit on the cycle where tick = 1 and msg_cnt = 1; go to EDIT if edit_req = 1, else TIME.
  - msg_start = 1 in any state → MSG, overriding every other transition in that cycle.
- msg_start handling:
  - Captures msg_hexs/msg_pts/msg_les and loads msg_cnt = MSG_TICKS.
  - In MSG, msg_cnt decrements on each tick.
  - Message occupies exactly MSG_TICKS*TICK_DIV cycles.
  - msg_start during MSG retriggers: new data is captured and the timer restarts.
- Blink:
  - blink_cnt counts ticks 0..BLINK_TICKS-1; blink_phase toggles on wrap.
  - Active only in EDIT; frozen in TIME and MSG.
  - On EDIT entry (from TIME or MSG): blink_cnt = 0 and blink_phase = 1, so edited digits are visible immediately.
- Outputs:
  - All outputs are registered and computed from the next state and the current inputs.
  - The owner change and data are visible at the same clock edge at which the state changes.
  - Input data reaches HEXS with 1-cycle latency.
- Output selection:
  - TIME: HEXS = time_hexs, points = time_pts, LES = 4'b1111, src = 0.
  - EDIT: HEXS = edit_hexs, points = edit_pts, LES = blink_phase ? 4'b1111 : ~edit_blink, src = 1.
  - MSG: HEXS/points/LES = captured message registers, src = 2, msg_busy = 1.
- msg_busy:
  - = 1 from the edge after msg_start up to and including the last MSG cycle.
  - Returns to 0 at the exit edge.
- Simultaneous events:
  - msg_start together with an edit_req change: MSG wins. edit_req is re-sampled at message exit.
  - msg_start on the expiry cycle: retrigger; the display stays in MSG.
  - edit_req toggling during MSG: ignored until exit.
- Widths: msg_cnt and blink_cnt sized to hold MSG_TICKS and BLINK_TICKS; no overflow is possible.

Test Plan:
All scenarios use TICK_DIV=4, BLINK_TICKS=2, MSG_TICKS=3.
- Reset, then release with time_hexs=16'h1234, time_pts=4'b0100 → after the first edge HEXS=16'h1234, LES=4'hF, points=4'b0100, src=0. While RST=0: LES=0, blink_phase=1.
- edit_req=1, edit_hexs=16'h0930, edit_blink=4'b0011 → src=1 next edge, LES=4'hF for 8 cycles, then 4'b1100 for 8 cycles, then repeating. edit_req=0 → src=0 next edge.
- One-cycle msg_start with msg_hexs=16'hAEEE, msg_les=4'b1000 → src=2, msg_busy=1, HEXS=16'hAEEE, LES=4'b1000 for exactly 12 cycles, then time display resumes.
- Retrigger: second msg_start 6 cycles into a message with msg_hexs=16'hBBBB → HEXS=16'hBBBB and msg_busy stays 1 for 12 more cycles (18 total).
- Message while edit_req=1: after expiry src=1, blink_phase=1, LES=4'hF for 8 cycles. msg_start in the same cycle as edit_req rising → src=2 first.
- Assert RST=0 mid-message → outputs go to reset values immediately. After release, msg_busy=0 and src=0 even if edit_req=0.
